// File: rtl/recip_arbiter_if.sv
// Requester, response and reciprocal-unit signals of the shared reciprocal arbiter.
// The slave modport is the arbiter side and the master modport is the surrounding logic.
interface recip_arbiter_if #(
    parameter int N = 4,
    parameter int W = 32
);
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_x;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   rsp_valid;
    logic [W-1:0]   rsp_data;
    logic           rsp_invalid;
    logic           rsp_timeout;
    logic           u_start;
    logic [W-1:0]   u_x;
    logic           u_done;
    logic [W-1:0]   u_x_inv;
    logic           u_invalid;
    logic           busy;

    modport slave (
        input  req_valid, req_x, u_done, u_x_inv, u_invalid,
        output req_ready, rsp_valid, rsp_data, rsp_invalid, rsp_timeout, u_start, u_x, busy
    );

    modport master (
        output req_valid, req_x, u_done, u_x_inv, u_invalid,
        input  req_ready, rsp_valid, rsp_data, rsp_invalid, rsp_timeout, u_start, u_x, busy
    );
endinterface

// File: rtl/recip_arbiter.sv
// Round-robin sequencer that shares one Q16 reciprocal unit between N requesters,
// one request in flight, with a bounded wait for the unit's done pulse.
module recip_arbiter #(
    parameter int N       = 4,
    parameter int W       = 32,
    parameter int TIMEOUT = 32
) (
    input  logic           clk,
    input  logic           rst,
    recip_arbiter_if.slave bus
);
    localparam int IDW = $clog2(N);
    localparam int WCW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t         state, state_nx;
    logic [IDW-1:0] ptr, cur, grant;
    logic           found;
    logic [IDW:0]   idx;
    logic [W-1:0]   grant_x;
    logic [W-1:0]   x_q, data_q;
    logic           inv_q, to_q;
    logic [WCW-1:0] wcnt;

    // First valid requester at or after ptr, wrapping; reset masks any grant.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            idx = {1'b0, ptr} + (IDW+1)'(i);
            if (idx >= (IDW+1)'(N)) idx = idx - (IDW+1)'(N);
            if (!found && !rst && bus.req_valid[idx[IDW-1:0]]) begin
                found = 1'b1;
                grant = idx[IDW-1:0];
            end
        end
    end

    always_comb begin
        grant_x = '0;
        for (int i = 0; i < N; i++)
            if (IDW'(i) == grant) grant_x = bus.req_x[i*W +: W];
    end

    always_comb begin
        state_nx      = state;
        bus.req_ready = '0;
        bus.rsp_valid = '0;
        bus.u_start   = 1'b0;
        case (state)
            IDLE: if (found) begin
                bus.req_ready[grant] = 1'b1;
                state_nx = ISSUE;
            end
            ISSUE: begin
                bus.u_start = 1'b1;
                state_nx    = WAIT;
            end
            WAIT: if (bus.u_done || wcnt == WCW'(TIMEOUT - 1)) state_nx = RESP;
            RESP: begin
                bus.rsp_valid[cur] = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            ptr    <= '0;
            cur    <= '0;
            x_q    <= '0;
            data_q <= '0;
            inv_q  <= 1'b0;
            to_q   <= 1'b0;
            wcnt   <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (found) begin
                    cur <= grant;
                    x_q <= grant_x;
                end
                ISSUE: wcnt <= '0;
                WAIT: begin
                    // done on the last wait cycle still counts as a real result
                    if (bus.u_done) begin
                        data_q <= bus.u_x_inv;
                        inv_q  <= bus.u_invalid;
                        to_q   <= 1'b0;
                    end else if (wcnt == WCW'(TIMEOUT - 1)) begin
                        data_q <= '0;
                        inv_q  <= 1'b0;
                        to_q   <= 1'b1;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                RESP: ptr <= (cur == IDW'(N - 1)) ? '0 : cur + 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.u_x         = x_q;
    assign bus.rsp_data    = data_q;
    assign bus.rsp_invalid = inv_q;
    assign bus.rsp_timeout = to_q;
    assign bus.busy        = (state != IDLE);
endmodule

// File: tb/tb_recip_arbiter.sv
// Randomised bench for recip_arbiter: a stub reciprocal unit plus a transaction-level
// model predicting grant order, response latency and response contents.
module tb_recip_arbiter;
    localparam int N  = 4;
    localparam int W  = 32;
    localparam int TO = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    recip_arbiter_if #(.N(N), .W(W)) ifc ();
    recip_arbiter #(.N(N), .W(W), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(ifc));

    logic [N-1:0]   vld, keep, acc;
    logic [N*W-1:0] xs;
    assign ifc.req_valid = vld;
    assign ifc.req_x     = xs;

    // stub modes: 0 Q16 unit, 1 never done, 2 done on last wait cycle, 3 done one cycle late
    int   mode;
    logic inject;
    bit   rnd;
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic logic [W-1:0] q16_recip(input logic [W-1:0] x);
        logic [63:0] num, den;
        if ($signed(x) <= 0) return '0;
        num = 64'h1_0000_0000;
        den = {32'b0, x};
        return W'(num / den);
    endfunction

    function automatic int stub_delay(input logic [W-1:0] x);
        if (mode == 0) return ($signed(x) > 0) ? 8 : 1;
        if (mode == 2) return TO - 1;
        return TO;
    endfunction

    int scnt;
    bit spend;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            spend <= 1'b0;
            scnt <= 0;
            ifc.u_done <= 1'b0;
            ifc.u_x_inv <= '0;
            ifc.u_invalid <= 1'b0;
        end else begin
            ifc.u_done <= inject;
            if (inject) begin
                ifc.u_x_inv <= 32'hDEAD_BEEF;
                ifc.u_invalid <= 1'b1;
            end
            if (spend) begin
                if (scnt == 1) begin
                    spend <= 1'b0;
                    ifc.u_done <= 1'b1;
                    ifc.u_x_inv <= (mode >= 2) ? ~ifc.u_x : q16_recip(ifc.u_x);
                    ifc.u_invalid <= (mode == 0) && ($signed(ifc.u_x) <= 0);
                end else begin
                    scnt <= scnt - 1;
                end
            end
            if (ifc.u_start && mode != 1) begin
                spend <= 1'b1;
                scnt <= stub_delay(ifc.u_x);
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // model state
    int   cyc = 0;
    bit   m_pend;
    int   m_ptr, m_id, m_t, m_lat;
    logic [W-1:0] m_x, m_data;
    logic m_inv, m_to;
    bit   x_ok;
    int   grants[$];

    task automatic monitor();
        int g, k;
        logic [N-1:0] em;
        cyc++;
        if (rst) begin
            m_pend = 0;
            m_ptr = 0;
            acc = '0;
            return;
        end
        acc = ifc.req_ready;
        if (!m_pend) begin
            if (ifc.rsp_valid != 0) chk("rsp_spurious", ifc.rsp_valid, 0);
            if (ifc.req_valid != 0 || ifc.req_ready != 0) begin
                g = -1;
                for (int i = 0; i < N; i++) begin
                    k = (m_ptr + i) % N;
                    if (g < 0 && ifc.req_valid[k]) g = k;
                end
                em = '0;
                if (g >= 0) em[g] = 1'b1;
                chk("grant", ifc.req_ready, em);
                if (g >= 0) begin
                    m_pend = 1;
                    m_id = g;
                    m_x = xs[g*W +: W];
                    m_t = cyc;
                    x_ok = 1;
                    grants.push_back(g);
                    m_inv = 0;
                    m_to = 0;
                    m_data = '0;
                    m_lat = TO + 2;
                    if (mode == 0) begin
                        if ($signed(m_x) > 0) begin
                            m_lat = 11;
                            m_data = q16_recip(m_x);
                        end else begin
                            m_lat = 4;
                            m_inv = 1;
                        end
                    end else if (mode == 2) begin
                        m_data = ~m_x;
                    end else begin
                        m_to = 1;
                    end
                end
            end
        end else begin
            if (ifc.req_ready != 0) chk("ready_busy", ifc.req_ready, 0);
            if (cyc == m_t + 1) chk("u_start", ifc.u_start, 1);
            else if (ifc.u_start) chk("u_start_extra", 1, 0);
            if (ifc.u_x != m_x) x_ok = 0;
            if (cyc == m_t + m_lat) begin
                em = '0;
                em[m_id] = 1'b1;
                chk("rsp_valid", ifc.rsp_valid, em);
                chk("rsp_data", ifc.rsp_data, m_data);
                chk("rsp_invalid", ifc.rsp_invalid, m_inv);
                chk("rsp_timeout", ifc.rsp_timeout, m_to);
                chk("u_x_stable", x_ok, 1);
                m_pend = 0;
                m_ptr = (m_id + 1) % N;
            end else if (ifc.rsp_valid != 0) begin
                chk("rsp_early", ifc.rsp_valid, 0);
            end
        end
    endtask

    function automatic logic [W-1:0] rand_pos();
        return ($urandom & 32'h00FF_FFFF) | 32'h0000_0100;
    endfunction

    function automatic logic [W-1:0] rand_x();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return '0;
        if (r == 1) return $urandom | 32'h8000_0000;
        return rand_pos();
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                vld[i] = keep[i];
                if (keep[i]) xs[i*W +: W] = rand_pos();
            end else if (rnd) begin
                if (vld[i] && $urandom_range(0, 19) == 0) begin
                    vld[i] = 1'b0;
                end else if (!vld[i] && $urandom_range(0, 5) == 0) begin
                    vld[i] = 1'b1;
                    xs[i*W +: W] = rand_x();
                end
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic wait_idle(input int budget, input string tag);
        for (int k = 0; k < budget; k++) begin
            step();
            if (!m_pend && !ifc.busy && vld == 0) return;
        end
        chk(tag, 0, 1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, ifc.req_ready, 0);
        chk({tag, "_rsp_valid"}, ifc.rsp_valid, 0);
        chk({tag, "_rsp_data"}, ifc.rsp_data, 0);
        chk({tag, "_rsp_invalid"}, ifc.rsp_invalid, 0);
        chk({tag, "_rsp_timeout"}, ifc.rsp_timeout, 0);
        chk({tag, "_u_start"}, ifc.u_start, 0);
        chk({tag, "_u_x"}, ifc.u_x, 0);
        chk({tag, "_busy"}, ifc.busy, 0);
    endtask

    initial begin
        vld = '0;
        keep = '0;
        acc = '0;
        xs = '0;
        mode = 0;
        inject = 1'b0;
        rnd = 0;
        m_pend = 0;
        m_ptr = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        // single requester, 2.0 -> 0.5
        xs[0*W +: W] = 32'h0002_0000;
        vld = 4'b0001;
        wait_idle(40, "t1_budget");
        chk("t1_data", ifc.rsp_data, 32'h0000_8000);

        // negative operand -> invalid
        xs[2*W +: W] = 32'hFFFF_0000;
        vld = 4'b0100;
        wait_idle(40, "t2_budget");
        chk("t2_invalid", ifc.rsp_invalid, 1);
        chk("t2_data", ifc.rsp_data, 0);

        // all requesters always valid from a fresh pointer
        rst = 1'b1;
        step();
        rst = 1'b0;
        grants.delete();
        for (int i = 0; i < N; i++) xs[i*W +: W] = 32'h0001_0000 * (i + 2);
        keep = '1;
        vld = '1;
        for (int k = 0; k < 100 && grants.size() < 5; k++) step();
        keep = '0;
        vld = '0;
        wait_idle(60, "t3_budget");
        for (int k = 0; k < 5; k++)
            chk("t3_order", (grants.size() > k) ? grants[k] : -1, k % N);

        // unit never answers
        mode = 1;
        xs[1*W +: W] = 32'h0003_0000;
        vld = 4'b0010;
        wait_idle(60, "t4_budget");
        chk("t4_timeout", ifc.rsp_timeout, 1);
        chk("t4_data", ifc.rsp_data, 0);
        inject = 1'b1;
        step();
        inject = 1'b0;
        repeat (3) step();
        chk("t4_late_done_busy", ifc.busy, 0);
        mode = 0;
        xs[1*W +: W] = 32'h0004_0000;
        vld = 4'b0010;
        wait_idle(40, "t4b_budget");
        chk("t4_next_data", ifc.rsp_data, 32'h0000_4000);
        chk("t4_next_timeout", ifc.rsp_timeout, 0);

        // done on the last wait cycle wins; one cycle later is a timeout
        mode = 2;
        xs[0*W +: W] = 32'h1234_5678;
        vld = 4'b0001;
        wait_idle(60, "t5_budget");
        chk("t5_timeout", ifc.rsp_timeout, 0);
        chk("t5_data", ifc.rsp_data, 32'hEDCB_A987);
        mode = 3;
        xs[3*W +: W] = 32'h0101_0101;
        vld = 4'b1000;
        wait_idle(60, "t5b_budget");
        chk("t5b_timeout", ifc.rsp_timeout, 1);

        // random traffic
        mode = 0;
        rnd = 1;
        repeat (3000) step();
        rnd = 0;
        vld = '0;
        wait_idle(40, "rand_budget");

        // reset in the middle of a wait
        xs[1*W +: W] = 32'h0005_0000;
        vld = 4'b0010;
        repeat (5) step();
        chk("t6_busy_before", ifc.busy, 1);
        rst = 1'b1;
        #1;
        chk_reset_outputs("t6_async");
        step();
        step();
        rst = 1'b0;
        grants.delete();
        xs[3*W +: W] = 32'h0008_0000;
        vld = 4'b1000;
        wait_idle(40, "t6_budget");
        chk("t6_first_grant", (grants.size() > 0) ? grants[0] : -1, 3);
        chk("t6_data", ifc.rsp_data, 32'h0000_2000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
